sram_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares a single-port synchronous SRAM (CS/WE/RD strobes, registered read data) between two independent request ports. It accepts at most one command per cycle, drives registered SRAM strobes, and returns read data to the owning port in request order, with fixed three-cycle read latency. It sits directly in front of the SRAM macro, between it and the comparator/test logic that currently drive it.

---
 rtl/sram_arbiter_if.sv | 50 +++++
 rtl/sram_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bundle for sram_arbiter: two request/response ports plus the SRAM macro pins.
// master = requesters together with the SRAM macro; slave = the arbiter.
interface sram_arbiter_if #(
    parameter int ADR = 8,
    parameter int DAT = 32
);
    logic           hold;
    logic           req0_valid;
    logic           req0_we;
    logic [ADR-1:0] req0_addr;
    logic [DAT-1:0] req0_wdata;
    logic           req0_ready;
    logic           req1_valid;
    logic           req1_we;
    logic [ADR-1:0] req1_addr;
    logic [DAT-1:0] req1_wdata;
    logic           req1_ready;
    logic           rsp0_valid;
    logic [DAT-1:0] rsp0_rdata;
    logic           rsp1_valid;
    logic [DAT-1:0] rsp1_rdata;
    logic           sram_CS;
    logic           sram_WE;
    logic           sram_RD;
    logic [ADR-1:0] sram_Addr;
    logic [DAT-1:0] sram_dataIn;
    logic [DAT-1:0] sram_dataOut;

    // Handshake: a command transfers on the rising Clk edge where reqN_valid & reqN_ready = 1;
    // valid may rise at any time, ready depends combinationally on valid, hold and arbitration.
    modport master (
        output hold,
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  sram_CS, sram_WE, sram_RD, sram_Addr, sram_dataIn,
        output sram_dataOut
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output sram_CS, sram_WE, sram_RD, sram_Addr, sram_dataIn,
        input  sram_dataOut
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a single-port synchronous SRAM; reads respond 3 cycles after acceptance.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module sram_arbiter #(
    parameter int ADR = 8,
    parameter int DAT = 32
) (
    input logic           Clk,
    input logic           Rst_n,
    sram_arbiter_if.slave bus
);
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic           sel_we;
    logic [ADR-1:0] sel_addr;
    logic [DAT-1:0] sel_wdata;

    logic           cs_q;
    logic           we_q;
    logic           rd_q;
    logic [ADR-1:0] addr_q;
    logic [DAT-1:0] din_q;
    logic [1:0]     s1_q;
    logic [1:0]     s2_q;
    logic           rsp0_valid_q;
    logic           rsp1_valid_q;
    logic [DAT-1:0] rsp0_rdata_q;
    logic [DAT-1:0] rsp1_rdata_q;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = port 1 was granted most recently, so port 0 wins the first contention after reset.
    logic last_grant_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant1;
        end
    end
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (Rst_n && !bus.hold) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
`else
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
`endif
        end
    end

    assign accept    = grant0 | grant1;
    assign sel_we    = grant1 ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cs_q   <= 1'b0;
            we_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            cs_q <= accept;
            we_q <= accept && sel_we;
            rd_q <= accept && !sel_we;
            if (accept) begin
                addr_q <= sel_addr;
                din_q  <= sel_wdata;
            end
        end
    end

    // {is_read, port} follows each command so the SRAM read data finds its owner two edges later.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= {accept && !sel_we, grant1};
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= s2_q[1] && !s2_q[0];
            rsp1_valid_q <= s2_q[1] && s2_q[0];
            if (s2_q[1] && !s2_q[0]) begin
                rsp0_rdata_q <= bus.sram_dataOut;
            end
            if (s2_q[1] && s2_q[0]) begin
                rsp1_rdata_q <= bus.sram_dataOut;
            end
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.sram_CS     = cs_q;
    assign bus.sram_WE     = we_q;
    assign bus.sram_RD     = rd_q;
    assign bus.sram_Addr   = addr_q;
    assign bus.sram_dataIn = din_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp0_rdata  = rsp0_rdata_q;
    assign bus.rsp1_rdata  = rsp1_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Build with SRAM_ARB_ROUND_ROBIN_EN defined to exercise the round-robin variant.
module tb_sram_arbiter;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    sram_arbiter_if bus ();

    sram_arbiter dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required finish before it", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- SRAM macro model (registered read) ----------------
    logic [31:0] sram_mem [256];

    always @(posedge Clk) begin
        if (bus.sram_CS) begin
            if (bus.sram_WE) sram_mem[bus.sram_Addr] <= bus.sram_dataIn;
            if (bus.sram_RD) bus.sram_dataOut <= sram_mem[bus.sram_Addr];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Memory contents are applied at acceptance time: commands execute in acceptance order,
    // so a later read always sees every earlier write.
    logic [31:0] model_mem [256];
    logic [64:0] exp_q[$];          // {due_cycle[31:0], port, data[31:0]}
    int          m_last;            // port granted most recently
    logic        m_cs, m_we, m_rd;
    logic [7:0]  m_addr;
    logic [31:0] m_din, m_rdata0, m_rdata1;

    function automatic int pick(input logic v0, input logic v1, input logic h);
        if (h || (!v0 && !v1)) return -1;
        if (v0 && v1) return RR ? (1 - m_last) : 0;
        return v0 ? 0 : 1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_last = 1;
        m_cs = 0; m_we = 0; m_rd = 0;
        m_addr = '0; m_din = '0; m_rdata0 = '0; m_rdata1 = '0;
    endtask

    always @(negedge Clk) begin
        int          g;
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [64:0] head;
        logic        ev0, ev1;
        logic [31:0] due;
        if (!Rst_n) begin
            check("rst_ready0", bus.req0_ready, 0);
            check("rst_ready1", bus.req1_ready, 0);
            check("rst_strobes", {bus.sram_CS, bus.sram_WE, bus.sram_RD}, 0);
            check("rst_addr_din", {bus.sram_Addr, bus.sram_dataIn}, 0);
            check("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
            check("rst_rdata", {bus.rsp0_rdata, bus.rsp1_rdata}, 0);
            model_reset();
        end else begin
            g = pick(bus.req0_valid, bus.req1_valid, bus.hold);
            check("ready0", bus.req0_ready, g == 0);
            check("ready1", bus.req1_ready, g == 1);
            check("sram_CS", bus.sram_CS, m_cs);
            check("sram_WE", bus.sram_WE, m_we);
            check("sram_RD", bus.sram_RD, m_rd);
            check("sram_Addr", bus.sram_Addr, m_addr);
            check("sram_dataIn", bus.sram_dataIn, m_din);
            ev0 = 0; ev1 = 0;
            if (exp_q.size() > 0 && exp_q[0][64:33] == cyc) begin
                head = exp_q.pop_front();
                if (head[32]) begin ev1 = 1; m_rdata1 = head[31:0]; end
                else          begin ev0 = 1; m_rdata0 = head[31:0]; end
            end
            check("rsp0_valid", bus.rsp0_valid, ev0);
            check("rsp1_valid", bus.rsp1_valid, ev1);
            check("rsp0_rdata", bus.rsp0_rdata, m_rdata0);
            check("rsp1_rdata", bus.rsp1_rdata, m_rdata1);
            if (g >= 0) begin
                we = (g == 1) ? bus.req1_we : bus.req0_we;
                a  = (g == 1) ? bus.req1_addr : bus.req0_addr;
                d  = (g == 1) ? bus.req1_wdata : bus.req0_wdata;
                m_cs = 1; m_we = we; m_rd = !we; m_addr = a; m_din = d;
                if (we) begin
                    model_mem[a] = d;
                end else begin
                    due = cyc + 3;
                    exp_q.push_back({due, (g == 1), model_mem[a]});
                end
                m_last = g;
            end else begin
                m_cs = 0; m_we = 0; m_rd = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic we0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic v1, input logic we1, input logic [7:0] a1, input logic [31:0] d1,
                         input logic h);
        bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
        bus.hold = h;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    endtask

    task automatic reset_pulse();
        Rst_n = 1'b0;
        next_cycle();
        Rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i]  = 32'hA5A5_0000 ^ (i * 32'h0001_0101);
            model_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0101);
        end
        bus.sram_dataOut = '0;
        model_reset();

        // Reset with both ports requesting.
        Rst_n = 1'b0;
        drive(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("lit_reset_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
        next_cycle();
        idle();
        Rst_n = 1'b1;
        next_cycle();

        // Write then read on port 0.
        drive(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 0);
        @(negedge Clk); check("lit_wr_ready0", bus.req0_ready, 1);
        next_cycle();
        drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
        @(negedge Clk);
        check("lit_rd_ready0", bus.req0_ready, 1);
        check("lit_wr_strobes", {bus.sram_CS, bus.sram_WE, bus.sram_RD}, 3'b110);
        check("lit_wr_addr", bus.sram_Addr, 8'h10);
        next_cycle(); idle();
        @(negedge Clk); check("lit_rd_strobes", {bus.sram_CS, bus.sram_WE, bus.sram_RD}, 3'b101);
        next_cycle();
        @(negedge Clk); check("lit_rd_early", bus.rsp0_valid, 0);
        next_cycle();
        @(negedge Clk);
        check("lit_rd_valid", bus.rsp0_valid, 1);
        check("lit_rd_data", bus.rsp0_rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge Clk);
        check("lit_rd_pulse", bus.rsp0_valid, 0);
        check("lit_rd_hold", bus.rsp0_rdata, 32'hDEADBEEF);

        // Contention from a fresh reset: both ports read every cycle for 6 cycles.
        next_cycle();
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 8'h20, 32'h0, 1, 0, 8'h21, 32'h0, 0);
            @(negedge Clk);
            check("lit_contend_ready0", bus.req0_ready, RR ? (i % 2 == 0) : 1'b1);
            check("lit_contend_ready1", bus.req1_ready, RR ? (i % 2 == 1) : 1'b0);
            next_cycle();
        end
        idle();
        repeat (4) next_cycle();

        // Cross-port read-after-write.
        drive(0, 0, 8'h00, 32'h0, 1, 1, 8'hFF, 32'h0000_00A5, 0);
        @(negedge Clk); check("lit_raw_ready1", bus.req1_ready, 1);
        next_cycle();
        drive(1, 0, 8'hFF, 32'h0, 0, 0, 8'h00, 32'h0, 0);
        @(negedge Clk); check("lit_raw_ready0", bus.req0_ready, 1);
        next_cycle(); idle();
        next_cycle(); next_cycle();
        @(negedge Clk);
        check("lit_raw_valid", bus.rsp0_valid, 1);
        check("lit_raw_data", bus.rsp0_rdata, 32'h0000_00A5);
        next_cycle();

        // hold raised one cycle after a read acceptance.
        drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
        @(negedge Clk); check("lit_hold_accept", bus.req0_ready, 1);
        next_cycle();
        drive(1, 0, 8'h10, 32'h0, 1, 0, 8'h11, 32'h0, 1);
        @(negedge Clk);
        check("lit_hold_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("lit_hold_inflight_cs", bus.sram_CS, 1);
        next_cycle();
        @(negedge Clk);
        check("lit_hold_cs_low", bus.sram_CS, 0);
        check("lit_hold_readys2", {bus.req0_ready, bus.req1_ready}, 2'b00);
        next_cycle();
        @(negedge Clk);
        check("lit_hold_rsp", {bus.rsp0_valid, bus.rsp0_rdata}, {1'b1, 32'hDEADBEEF});
        next_cycle();
        bus.hold = 1'b0;
        @(negedge Clk); check("lit_hold_resume", bus.req0_ready | bus.req1_ready, 1);
        next_cycle(); idle();
        repeat (4) next_cycle();

        // Reset pulse while a read is in flight.
        drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
        @(negedge Clk); check("lit_mrst_accept", bus.req0_ready, 1);
        next_cycle(); idle();
        check("lit_mrst_cs_before", bus.sram_CS, 1);
        Rst_n = 1'b0;
        #1;
        check("lit_mrst_strobes", {bus.sram_CS, bus.sram_WE, bus.sram_RD}, 3'b000);
        next_cycle();
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk); check("lit_mrst_no_rsp", bus.rsp0_valid, 0);
            next_cycle();
        end

        // Randomized traffic over a small address window to hit read-after-write often.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 7) == 0);
            next_cycle();
        end
        idle();
        repeat (6) next_cycle();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
